reg_command_controller: RTL

- Parametrised successor to the UART write controller. Decodes framed UART packets into register-bus write and read commands.
- Multi-byte address, configurable data width, per-packet length checking, inactivity timeout and saturating error count.
- Read commands return the register contents as a framed response packet with valid/ready backpressure.
- Sits between the UART receive packetiser and the register file, with its response stream feeding the UART transmit path.

---
 rtl/reg_command_controller.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/reg_command_controller.sv
// Register command controller: decodes framed UART packets into register bus
// writes and reads, and returns read data as a framed response packet.
package reg_command_controller_pkg;
  typedef struct packed {
    logic [7:0] source;
    logic [7:0] destination;
    logic [7:0] length;
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       valid;
  } uart_packet_t;
endpackage

module reg_command_controller
  import reg_command_controller_pkg::*;
#(
  parameter int unsigned ADDR_BYTES     = 1,
  parameter int unsigned DATA_BYTES     = 4,
  parameter logic [7:0]  WR_SOURCE      = 8'h01,
  parameter logic [7:0]  RD_SOURCE      = 8'h02,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    ipClk,
  input  logic                    ipReset,
  input  uart_packet_t            ipRxStream,
  output logic                    opWrEnable,
  output logic                    opRdEnable,
  output logic [8*ADDR_BYTES-1:0] opAddress,
  output logic [8*DATA_BYTES-1:0] opWrData,
  input  logic                    ipRdValid,
  input  logic [8*DATA_BYTES-1:0] ipRdData,
  output uart_packet_t            opTxStream,
  input  logic                    ipTxReady,
  output logic                    opBusy,
  output logic [7:0]              opErrorCount
);

  localparam int unsigned AW = 8 * ADDR_BYTES;
  localparam int unsigned DW = 8 * DATA_BYTES;
  localparam int unsigned RW = AW + DW;
  localparam int unsigned NB = ADDR_BYTES + DATA_BYTES;
  localparam int unsigned CW = $clog2(NB + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, DISCARD, WAIT_RD, SEND_RESP
  } state_t;

  state_t        state;
  logic          is_rd;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;
  logic [AW-1:0] addr_shift;
  logic [DW-1:0] data_shift;
  logic [RW-1:0] resp;
  logic          err_evt;

  logic          rx_byte, rx_sop, eop, in_pkt, start, addr_byte;
  logic          addr_last, data_last, pkt_rd, timer_hit;
  logic [AW-1:0] addr_val;
  logic [DW-1:0] data_val;
  logic          unused_rx_fields;

  // Byte classification; a valid start byte is treated as address byte 0 in any receive state
  assign rx_byte   = ipRxStream.valid;
  assign rx_sop    = ipRxStream.valid & ipRxStream.sop;
  assign eop       = ipRxStream.eop;
  assign in_pkt    = state inside {GET_ADDR, GET_DATA, DISCARD};
  assign start     = (in_pkt || state == IDLE) && rx_sop &&
                     (ipRxStream.source == WR_SOURCE || ipRxStream.source == RD_SOURCE);
  assign addr_byte = start || (state == GET_ADDR && rx_byte && !ipRxStream.sop);
  assign addr_val  = start ? AW'(ipRxStream.data) : ((addr_shift << 8) | AW'(ipRxStream.data));
  assign addr_last = start ? (ADDR_BYTES == 1) : (cnt == CW'(ADDR_BYTES - 1));
  assign pkt_rd    = start ? (ipRxStream.source == RD_SOURCE) : is_rd;
  assign data_val  = (data_shift << 8) | DW'(ipRxStream.data);
  assign data_last = cnt == CW'(DATA_BYTES - 1);
  assign timer_hit = timer == TW'(TIMEOUT_CYCLES - 1);
  assign opBusy    = state != IDLE;
  assign unused_rx_fields = ^{ipRxStream.destination, ipRxStream.length};

  // Errors are flagged for one cycle and folded into the saturating count on the next
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state        <= IDLE;
      is_rd        <= 1'b0;
      cnt          <= '0;
      timer        <= '0;
      addr_shift   <= '0;
      data_shift   <= '0;
      resp         <= '0;
      err_evt      <= 1'b0;
      opWrEnable   <= 1'b0;
      opRdEnable   <= 1'b0;
      opAddress    <= '0;
      opWrData     <= '0;
      opTxStream   <= '0;
      opErrorCount <= '0;
    end else begin
      opWrEnable <= 1'b0;
      opRdEnable <= 1'b0;
      err_evt    <= 1'b0;
      if (err_evt && opErrorCount != 8'hFF) opErrorCount <= opErrorCount + 8'd1;
      case (state)
        IDLE, GET_ADDR, GET_DATA, DISCARD: begin
          timer <= '0;
          if (rx_sop && in_pkt) err_evt <= 1'b1;
          if (addr_byte) begin
            addr_shift <= addr_val;
            is_rd      <= pkt_rd;
            cnt        <= start ? CW'(1) : cnt + CW'(1);
            if (addr_last) begin
              cnt <= '0;
              if (pkt_rd && eop) begin
                opRdEnable <= 1'b1;
                opAddress  <= addr_val;
                state      <= WAIT_RD;
              end else if (pkt_rd || eop) begin
                err_evt <= 1'b1;
                state   <= pkt_rd ? DISCARD : IDLE;
              end else begin
                state <= GET_DATA;
              end
            end else if (eop) begin
              err_evt <= 1'b1;
              state   <= IDLE;
            end else begin
              state <= GET_ADDR;
            end
          end else if (rx_sop) begin
            state <= IDLE;
          end else if (rx_byte) begin
            if (state == GET_DATA) begin
              data_shift <= data_val;
              cnt        <= cnt + CW'(1);
              if (data_last && eop) begin
                opWrEnable <= 1'b1;
                opAddress  <= addr_shift;
                opWrData   <= data_val;
                state      <= IDLE;
              end else if (data_last || eop) begin
                err_evt <= 1'b1;
                state   <= eop ? IDLE : DISCARD;
              end
            end else if (state == DISCARD && eop) begin
              state <= IDLE;
            end
          end else if (in_pkt) begin
            if (timer_hit) begin
              err_evt <= 1'b1;
              state   <= IDLE;
            end else begin
              timer <= timer + TW'(1);
            end
          end
        end
        WAIT_RD: begin
          if (rx_sop) err_evt <= 1'b1;
          if (ipRdValid) begin
            resp              <= {opAddress, ipRdData} << 8;
            opTxStream.source <= RD_SOURCE;
            opTxStream.data   <= opAddress[AW-1 -: 8];
            opTxStream.sop    <= 1'b1;
            opTxStream.eop    <= 1'b0;
            opTxStream.valid  <= 1'b1;
            cnt               <= '0;
            state             <= SEND_RESP;
          end else if (timer_hit) begin
            err_evt <= 1'b1;
            state   <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        SEND_RESP: begin
          if (rx_sop) err_evt <= 1'b1;
          if (opTxStream.valid && ipTxReady) begin
            if (cnt == CW'(NB - 1)) begin
              opTxStream <= '0;
              state      <= IDLE;
            end else begin
              opTxStream.data <= resp[RW-1 -: 8];
              opTxStream.sop  <= 1'b0;
              opTxStream.eop  <= cnt == CW'(NB - 2);
              resp            <= resp << 8;
              cnt             <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
